// File: rtl/channelizer_scheduler_pkg.sv
// Shared types for the channelizer scheduler: channel-tracking FSM states and
// the drop counter width used when CHANSCHED_STATS_EN is defined.
package channelizer_scheduler_pkg;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } chan_state_t;

    localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/channelizer_scheduler_sync_fifo.sv
// Single-clock FIFO holding upstream samples ahead of the channelizer pacer.
// A push while full is only accepted when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int DW        = 33,
    parameter int LOG_DEPTH = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty
);

    localparam int DEPTH = 1 << LOG_DEPTH;

    logic [DW-1:0]        mem [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr;
    logic [LOG_DEPTH-1:0] rd_ptr;
    logic [LOG_DEPTH:0]   count;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count == (LOG_DEPTH+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + LOG_DEPTH'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + LOG_DEPTH'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (LOG_DEPTH+1)'(1);
                2'b01:   count <= count - (LOG_DEPTH+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/channelizer_scheduler.sv
// Channelizer front/back-end controller: paces buffered samples into the
// channelizer and forwards masked, channel-tagged outputs. Optional macro
// CHANSCHED_STATS_EN adds the saturating drop_count output.
module channelizer_scheduler
    import channelizer_scheduler_pkg::*;
#(
    parameter int N         = 8,
    parameter int LOG_N     = 3,
    parameter int WIDTH     = 32,
    parameter int MWIDTH    = 1,
    parameter int LOG_DEPTH = 3,
    parameter int MIN_GAP   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  up_data,
    input  logic [MWIDTH-1:0] up_m,
    input  logic              up_nd,
    output logic [WIDTH-1:0]  ch_in_data,
    output logic [MWIDTH-1:0] ch_in_m,
    output logic              ch_in_nd,
    input  logic [WIDTH-1:0]  ch_out_data,
    input  logic [MWIDTH-1:0] ch_out_m,
    input  logic              ch_out_nd,
    input  logic              ch_first_channel,
    input  logic              ch_error,
    input  logic [N-1:0]      cfg_mask,
    input  logic              cfg_mask_wr,
    input  logic              clear_err,
    output logic [WIDTH-1:0]  dn_data,
    output logic [MWIDTH-1:0] dn_m,
    output logic [LOG_N-1:0]  dn_chan,
    output logic              dn_nd,
    output logic              overflow,
    output logic              sync_error,
    output logic              chan_error
`ifdef CHANSCHED_STATS_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_count
`endif
);

    localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

    logic [WIDTH+MWIDTH-1:0] fifo_rd;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    pop;
    logic                    drop;
    logic [GAP_W-1:0]        gap_cnt;

    chan_state_t             state;
    chan_state_t             next_state;
    logic [LOG_N-1:0]        idx;
    logic [LOG_N-1:0]        next_idx;
    logic [LOG_N-1:0]        exp_chan;
    logic [LOG_N-1:0]        sample_chan;
    logic                    sample_ok;
    logic                    sync_evt;
    logic                    fwd;
    logic [N-1:0]            active_mask;
    logic [N-1:0]            pending_mask;
    logic [N-1:0]            pending_eff;
    logic [N-1:0]            mask_eff;

    assign pop  = !fifo_empty && (gap_cnt == '0);
    assign drop = up_nd && fifo_full && !pop;

    sync_fifo #(
        .DW        (WIDTH + MWIDTH),
        .LOG_DEPTH (LOG_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (up_nd),
        .pop     (pop),
        .wr_data ({up_m, up_data}),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            gap_cnt    <= '0;
            ch_in_nd   <= 1'b0;
            ch_in_data <= '0;
            ch_in_m    <= '0;
        end else begin
            ch_in_nd <= pop;
            if (pop) begin
                {ch_in_m, ch_in_data} <= fifo_rd;
                gap_cnt               <= GAP_W'(MIN_GAP - 1);
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
        end
    end

    // A first_channel sample always restarts the frame at channel 0; a frame
    // wrap without it means we lost alignment and must wait for the next one.
    always_comb begin
        next_state  = state;
        next_idx    = idx;
        sample_ok   = 1'b0;
        sample_chan = '0;
        sync_evt    = 1'b0;
        exp_chan    = idx + LOG_N'(1);
        pending_eff = cfg_mask_wr ? cfg_mask : pending_mask;
        if (ch_out_nd) begin
            case (state)
                SYNC: begin
                    if (ch_first_channel) begin
                        next_state = RUN;
                        next_idx   = '0;
                        sample_ok  = 1'b1;
                    end
                end
                RUN: begin
                    if (ch_first_channel) begin
                        sync_evt  = (exp_chan != '0);
                        next_idx  = '0;
                        sample_ok = 1'b1;
                    end else if (exp_chan == '0) begin
                        sync_evt   = 1'b1;
                        next_state = SYNC;
                    end else begin
                        next_idx    = exp_chan;
                        sample_ok   = 1'b1;
                        sample_chan = exp_chan;
                    end
                end
                default: next_state = SYNC;
            endcase
        end
        mask_eff = (sample_ok && sample_chan == '0) ? pending_eff : active_mask;
        fwd      = sample_ok && mask_eff[sample_chan];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= SYNC;
            idx          <= '0;
            active_mask  <= '1;
            pending_mask <= '1;
            dn_nd        <= 1'b0;
            dn_data      <= '0;
            dn_m         <= '0;
            dn_chan      <= '0;
        end else begin
            state <= next_state;
            idx   <= next_idx;
            dn_nd <= fwd;
            if (cfg_mask_wr) begin
                pending_mask <= cfg_mask;
            end
            if (sample_ok && sample_chan == '0) begin
                active_mask <= pending_eff;
            end
            if (fwd) begin
                dn_data <= ch_out_data;
                dn_m    <= ch_out_m;
                dn_chan <= sample_chan;
            end
        end
    end

    // Sticky flags: a new event in the clearing cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow   <= 1'b0;
            sync_error <= 1'b0;
            chan_error <= 1'b0;
        end else begin
            overflow   <= drop     || (overflow   && !clear_err);
            sync_error <= sync_evt || (sync_error && !clear_err);
            chan_error <= ch_error || (chan_error && !clear_err);
        end
    end

`ifdef CHANSCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count <= '0;
        end else if (clear_err) begin
            drop_count <= drop ? DROP_CNT_W'(1) : '0;
        end else if (drop && drop_count != '1) begin
            drop_count <= drop_count + DROP_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_channelizer_scheduler.sv
// Randomized scoreboard bench for channelizer_scheduler; a queue-based reference
// model predicts paced channelizer inputs, forwarded samples and sticky flags.
module tb_channelizer_scheduler;

    localparam int N       = 8;
    localparam int LOG_N   = 3;
    localparam int WIDTH   = 32;
    localparam int MWIDTH  = 1;
    localparam int DEPTH   = 8;
    localparam int MIN_GAP = 8;

    typedef struct {
        logic [WIDTH-1:0]  d;
        logic [MWIDTH-1:0] m;
        logic [LOG_N-1:0]  ch;
    } item_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [WIDTH-1:0]  up_data;
    logic [MWIDTH-1:0] up_m;
    logic              up_nd;
    logic [WIDTH-1:0]  ch_in_data;
    logic [MWIDTH-1:0] ch_in_m;
    logic              ch_in_nd;
    logic [WIDTH-1:0]  ch_out_data;
    logic [MWIDTH-1:0] ch_out_m;
    logic              ch_out_nd;
    logic              ch_first_channel;
    logic              ch_error;
    logic [N-1:0]      cfg_mask;
    logic              cfg_mask_wr;
    logic              clear_err;
    logic [WIDTH-1:0]  dn_data;
    logic [MWIDTH-1:0] dn_m;
    logic [LOG_N-1:0]  dn_chan;
    logic              dn_nd;
    logic              overflow;
    logic              sync_error;
    logic              chan_error;
`ifdef CHANSCHED_STATS_EN
    logic [15:0]       drop_count;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model state
    item_t       fifo_q[$];
    item_t       exp_in[$];
    item_t       exp_dn[$];
    int          cyc      = 0;
    int          last_pop = -1000;
    bit          m_run;
    int          m_chan;
    logic [N-1:0] m_active;
    logic [N-1:0] m_pending;
    bit          m_ovf, m_sync, m_cerr;
    int          m_drops;
    int          gen_pos = 0;
    int          burst   = 0;

    channelizer_scheduler #(
        .N(N), .LOG_N(LOG_N), .WIDTH(WIDTH), .MWIDTH(MWIDTH),
        .LOG_DEPTH(3), .MIN_GAP(MIN_GAP)
    ) dut (
        .clk(clk), .rst(rst),
        .up_data(up_data), .up_m(up_m), .up_nd(up_nd),
        .ch_in_data(ch_in_data), .ch_in_m(ch_in_m), .ch_in_nd(ch_in_nd),
        .ch_out_data(ch_out_data), .ch_out_m(ch_out_m), .ch_out_nd(ch_out_nd),
        .ch_first_channel(ch_first_channel), .ch_error(ch_error),
        .cfg_mask(cfg_mask), .cfg_mask_wr(cfg_mask_wr), .clear_err(clear_err),
        .dn_data(dn_data), .dn_m(dn_m), .dn_chan(dn_chan), .dn_nd(dn_nd),
        .overflow(overflow), .sync_error(sync_error), .chan_error(chan_error)
`ifdef CHANSCHED_STATS_EN
        , .drop_count(drop_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic resetModel();
        fifo_q.delete();
        exp_in.delete();
        exp_dn.delete();
        last_pop  = -1000;
        m_run     = 0;
        m_chan    = 0;
        m_active  = '1;
        m_pending = '1;
        m_ovf     = 0;
        m_sync    = 0;
        m_cerr    = 0;
        m_drops   = 0;
    endtask

    // One clock edge of the reference model, using the inputs held this cycle.
    task automatic modelStep();
        item_t        it;
        bit           drop_now, sync_now, accept;
        int           chan;
        logic [N-1:0] pend_now;
        cyc++;
        if (rst) begin
            resetModel();
            return;
        end
        // Pacing: at most one sample every MIN_GAP cycles, FIFO order kept
        if (fifo_q.size() > 0 && (cyc - last_pop) >= MIN_GAP) begin
            exp_in.push_back(fifo_q.pop_front());
            last_pop = cyc;
        end
        drop_now = 0;
        if (up_nd) begin
            if (fifo_q.size() < DEPTH) begin
                it.d = up_data; it.m = up_m; it.ch = '0;
                fifo_q.push_back(it);
            end else begin
                drop_now = 1;
            end
        end
        // Channel tracking
        sync_now = 0;
        accept   = 0;
        chan     = 0;
        pend_now = cfg_mask_wr ? cfg_mask : m_pending;
        if (ch_out_nd) begin
            if (!m_run) begin
                if (ch_first_channel) begin
                    m_run = 1; chan = 0; accept = 1;
                end
            end else begin
                int nxt = (m_chan + 1) % N;
                if (ch_first_channel) begin
                    if (nxt != 0) sync_now = 1;
                    chan = 0; accept = 1;
                end else if (nxt == 0) begin
                    sync_now = 1; m_run = 0;
                end else begin
                    chan = nxt; accept = 1;
                end
            end
        end
        if (accept) begin
            m_chan = chan;
            if (chan == 0) m_active = pend_now;
            if (m_active[chan]) begin
                it.d = ch_out_data; it.m = ch_out_m; it.ch = LOG_N'(chan);
                exp_dn.push_back(it);
            end
        end
        if (cfg_mask_wr) m_pending = cfg_mask;
        m_ovf  = drop_now || (m_ovf  && !clear_err);
        m_sync = sync_now || (m_sync && !clear_err);
        m_cerr = ch_error || (m_cerr && !clear_err);
        if (clear_err) m_drops = drop_now ? 1 : 0;
        else if (drop_now && m_drops < 65535) m_drops++;
    endtask

    task automatic applyStimulus(input bit quiet);
        up_nd       = 0;
        ch_out_nd   = 0;
        ch_error    = 0;
        cfg_mask_wr = 0;
        clear_err   = 0;
        up_data     = $urandom;
        up_m        = MWIDTH'($urandom);
        ch_out_data = $urandom;
        ch_out_m    = MWIDTH'($urandom);
        cfg_mask    = N'($urandom);
        ch_first_channel = 0;
        if (quiet) return;
        if (burst > 0) begin
            up_nd = 1; burst--;
        end else if ($urandom_range(0, 149) == 0) begin
            burst = $urandom_range(9, 12);
        end else begin
            up_nd = ($urandom_range(0, 9) == 0);
        end
        if ($urandom_range(0, 1) == 0) begin
            int r = $urandom_range(0, 39);
            ch_out_nd = 1;
            ch_first_channel = (gen_pos == 0);
            if (r == 0) ch_first_channel = !ch_first_channel;
            if (r == 1) gen_pos = $urandom_range(0, N - 1);
            gen_pos = (gen_pos + 1) % N;
        end
        cfg_mask_wr = ($urandom_range(0, 29) == 0);
        ch_error    = ($urandom_range(0, 199) == 0);
        clear_err   = ($urandom_range(0, 59) == 0);
    endtask

    task automatic checkFlags();
        checkOutput("overflow", 64'(overflow), 64'(m_ovf));
        checkOutput("sync_error", 64'(sync_error), 64'(m_sync));
        checkOutput("chan_error", 64'(chan_error), 64'(m_cerr));
`ifdef CHANSCHED_STATS_EN
        checkOutput("drop_count", 64'(drop_count), 64'(m_drops));
`endif
    endtask

    // Monitor: pops an expectation whenever the DUT strobes, and flags misses.
    always @(posedge clk) begin
        item_t e;
        #2;
        if (ch_in_nd) begin
            if (exp_in.size() == 0) begin
                checkOutput("ch_in_nd_unexpected", 64'(1), 64'(0));
            end else begin
                e = exp_in.pop_front();
                checkOutput("ch_in_data", 64'(ch_in_data), 64'(e.d));
                checkOutput("ch_in_m", 64'(ch_in_m), 64'(e.m));
            end
        end else if (exp_in.size() != 0) begin
            void'(exp_in.pop_front());
            checkOutput("ch_in_nd_missing", 64'(0), 64'(1));
        end
        if (dn_nd) begin
            if (exp_dn.size() == 0) begin
                checkOutput("dn_nd_unexpected", 64'(1), 64'(0));
            end else begin
                e = exp_dn.pop_front();
                checkOutput("dn_data", 64'(dn_data), 64'(e.d));
                checkOutput("dn_m", 64'(dn_m), 64'(e.m));
                checkOutput("dn_chan", 64'(dn_chan), 64'(e.ch));
            end
        end else if (exp_dn.size() != 0) begin
            void'(exp_dn.pop_front());
            checkOutput("dn_nd_missing", 64'(0), 64'(1));
        end
    end

    task automatic runCycle(input bit quiet, input bit do_rst);
        @(negedge clk);
        applyStimulus(quiet);
        rst = do_rst;
        @(posedge clk);
        modelStep();
        #1;
        checkFlags();
    endtask

    initial begin
        rst = 1;
        applyStimulus(1'b1);
        resetModel();
        repeat (3) begin
            @(posedge clk);
            modelStep();
            #1;
            checkOutput("reset_ch_in_nd", 64'(ch_in_nd), 64'(0));
            checkOutput("reset_ch_in_data", 64'(ch_in_data), 64'(0));
            checkOutput("reset_dn_nd", 64'(dn_nd), 64'(0));
            checkOutput("reset_dn_data", 64'(dn_data), 64'(0));
            checkOutput("reset_dn_chan", 64'(dn_chan), 64'(0));
            checkFlags();
        end
        for (int c = 0; c < 4000; c++) begin
            runCycle(1'b0, (c == 2000));
        end
        for (int c = 0; c < 120; c++) begin
            runCycle(1'b1, 1'b0);
        end
        checkOutput("drain_fifo_model_empty", 64'(fifo_q.size()), 64'(0));
        checkOutput("drain_exp_in_empty", 64'(exp_in.size()), 64'(0));
        checkOutput("drain_exp_dn_empty", 64'(exp_dn.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
